// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
// MDU_FAST_MUL_EN selects a single-cycle multiply; divide is always iterative.
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] opd;
  logic             is_mul;
  logic             neg_q;
  logic             neg_r;
  logic             div0;

  logic             sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] quo_n;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  assign sgn      = ~op[0];
  assign a_mag    = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag    = (sgn && b[WIDTH-1]) ? -b : b;
  assign prod     = {acc, quo};
  assign prod_fix = neg_q ? -prod : prod;

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{sgn & a[WIDTH-1]}}, a} * {{WIDTH{sgn & b[WIDTH-1]}}, b};
`endif

  // One shift-add (multiply) or restoring-subtract (divide) step per cycle.
  always_comb begin
    sum     = {1'b0, acc} + (quo[0] ? {1'b0, opd} : '0);
    shifted = {acc, quo[WIDTH-1]};
    diff    = shifted - {1'b0, opd};
    if (is_mul) begin
      acc_n = sum[WIDTH:1];
      quo_n = {sum[0], quo[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_n = diff[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = shifted[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      quo    <= '0;
      opd    <= '0;
      is_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            is_mul <= ~op[1];
            quo    <= op[1] ? a_mag : b_mag;
            opd    <= op[1] ? b_mag : a_mag;
            neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sgn & a[WIDTH-1];
            div0   <= op[1] & (b == '0);
`ifdef MDU_FAST_MUL_EN
            // Product is already signed-correct, so FIX only copies it out.
            if (!op[1]) begin
              state <= FIX;
              acc   <= fast_prod[2*WIDTH-1:WIDTH];
              quo   <= fast_prod[WIDTH-1:0];
              neg_q <= 1'b0;
            end
`endif
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          acc <= acc_n;
          quo <= quo_n;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (is_mul) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else begin
            hi <= neg_r ? -acc : acc;
            lo <= div0 ? '1 : (neg_q ? -quo : quo);
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - directed self-checking bench for mdu_iterative
module tb_mdu_iterative;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_iterative #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int mul_lat(input logic [1:0] o);
`ifdef MDU_FAST_MUL_EN
    return o[1] ? W + 1 : 1;
`else
    return W + 1;
`endif
  endfunction

  // Called at a negedge; start is driven immediately, so back-to-back runs
  // exercise a start in the same cycle that done is high.
  task automatic run(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic [W-1:0] eh,
                     input logic [W-1:0] el, input bit inj);
    logic [W-1:0] ph, pl;
    int k;
    ph = hi; pl = lo;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0; op = ~o; a = ~x; b = ~y;
    k = 0;
    check({tag, "_done_fall"}, {63'd0, done}, 64'd0);
    while (!done && k < 100) begin
      if (k == 1) check({tag, "_busy_run"}, {63'd0, busy}, 64'd1);
      if (inj && k == 5) begin
        start = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
      end
      @(negedge clock);
      k++;
      start = 1'b0; lo_we = 1'b0;
      if (k == W) begin
        check({tag, "_hi_hold"}, {32'd0, hi}, {32'd0, ph});
        check({tag, "_lo_hold"}, {32'd0, lo}, {32'd0, pl});
      end
    end
    check({tag, "_lat"}, 64'(k), 64'(mul_lat(o)));
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
    check({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int n_done;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    reset = 1'b1;
    @(negedge clock);

    hi_we = 1'b1; wdata = 32'h12345678;
    @(negedge clock);
    hi_we = 1'b0;
    check("mthi", {32'd0, hi}, 64'h12345678);
    check("mthi_lo", {32'd0, lo}, 64'd0);
    lo_we = 1'b1; wdata = 32'hCAFEF00D;
    @(negedge clock);
    lo_we = 1'b0;
    check("mtlo", {32'd0, lo}, 64'hCAFEF00D);

    run("mult",  2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run("multu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run("div",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("divu0", 2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1);
    run("divu",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b1);

    // No queued start: the injected mid-op start must not launch another run.
    n_done = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) n_done++;
    end
    check("no_queue", 64'(n_done), 64'd0);

    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);

    start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    n_done = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised multiply/divide unit for the MIPS32 core; owns the HI/LO register pair.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, and supports MTHI/MTLO writes. MFHI/MFLO read the hi/lo outputs directly.
- Sits beside the ALU in the execute stage. The pipeline stalls on busy and resumes on done.

Parameters:
- WIDTH, 32: operand width and HI/LO width; must be >= 4 and even.
- CNT_W, 6: width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when hi/lo hold a new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset takes priority over everything, including mid-operation. An aborted operation never produces done.
- States and transitions:
  - IDLE -> CALC when start=1.
  - CALC -> FIX after WIDTH iterations.
  - FIX -> IDLE unconditionally.
- Timing: start is sampled at edge E0.
  - busy=1 after E0.
  - CALC occupies edges E1..E_WIDTH.
  - At E_{WIDTH+1}: hi/lo are written, done=1, busy=0.
  - done falls after the next edge.
  - A new start is accepted in the same cycle done=1, since the state is IDLE.
- Operand capture: a, b and op are latched at E0. Later changes to the inputs have no effect.
- Multiply: shift-add on |a| and |b| (signed) or raw values (unsigned). The 2*WIDTH product is split {hi,lo}. FIX negates the product when the signed operand signs differ.
- Divide: restoring division on magnitudes; lo=quotient, hi=remainder.
  - Signed results truncate toward zero; the remainder takes the sign of the dividend (applied in FIX).
  - Divide by zero (b=0, DIV or DIVU): lo={WIDTH{1'b1}}, hi=a. Same latency.
  - Signed overflow (a=most negative, b=-1): lo=a, hi=0.
- start while busy=1: ignored, no queuing.
- hi_we/lo_we:
  - In IDLE with start=0: hi/lo <= wdata at the next edge. Both may be asserted together.
  - While busy, or when start=1 in the same cycle: ignored.
- hi/lo keep their previous values throughout CALC. They change only at FIX, on an MTHI/MTLO write, or on reset.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle combinational WIDTH x WIDTH signed/unsigned multiply.
  - Start at E0 -> hi/lo written and done=1 at E1; busy=1 for one cycle.
  - Divide is unchanged (WIDTH+1 latency).
- Undefined: all operations use the iterative path with WIDTH+1 latency.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> done at E33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high E1..E32.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. With MDU_FAST_MUL_EN: done at E1, same values.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; both hi and lo at 0 before E33 if previously reset.
- Start MULTU, pulse reset=0 at E10 -> busy=0, done=0, hi=lo=0, and no done pulse in the following 40 cycles.
- hi_we=1, wdata=0x12345678 in IDLE -> hi=0x12345678 next cycle. Assert start and lo_we while busy -> both ignored; lo unchanged until done.
